scroll_select_seq: RTL and testbench

//  Sequencer that drives the select lines of the eight 3-bit-wide 8-to-1 display muxes.

---
 rtl/scroll_select_seq_pkg.sv | 19 +
 rtl/scroll_select_seq_if.sv | 16 +
 rtl/scroll_select_seq_tick_prescaler.sv | 29 ++
 rtl/scroll_select_seq.sv | 97 +++++++++
 tb/tb_scroll_select_seq.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/scroll_select_seq_pkg.sv
// Shared definitions for the scroll select sequencer: display geometry,
// FSM state encoding and the lane select arithmetic.
package scroll_select_seq_pkg;

    localparam int NPOS = 8;   // number of display positions
    localparam int SELW = 3;   // width of one mux select

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Select for display lane: (offset + lane) truncated to SELW bits, so it wraps mod 8.
    function automatic logic [SELW-1:0] lane_sel(input logic [SELW-1:0] off,
                                                 input int unsigned     lane);
        return SELW'(32'(off) + lane);
    endfunction

endpackage

// File: rtl/scroll_select_seq_if.sv
// Control inputs and select/status outputs of the scroll sequencer.
// The master side drives Run/Dir/Step; the sequencer is the slave.
interface scroll_select_seq_if;
    import scroll_select_seq_pkg::*;

    logic                 Run;
    logic                 Dir;
    logic                 Step;
    logic [SELW-1:0]      Offset;
    logic [NPOS*SELW-1:0] Sel;
    logic                 Tick;

    modport master (output Run, Dir, Step, input Offset, Sel, Tick);
    modport slave  (input Run, Dir, Step, output Offset, Sel, Tick);

endinterface

// File: rtl/scroll_select_seq_tick_prescaler.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle.
// The count is held (not cleared) while disabled so a pause keeps the phase.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000,
    parameter int TDW      = 26
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic En,
    output logic Tick
);

    localparam logic [TDW-1:0] LAST = TDW'(TICK_DIV - 1);

    logic [TDW-1:0] r_cnt;

    // Wrap flag is combinational so the consumer can register its effect on the wrap edge.
    assign Tick = En && (r_cnt == LAST);

    // Phase counter: advance when enabled, wrap to zero after the last count.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_cnt <= '0;
        end else if (En) begin
            r_cnt <= Tick ? '0 : r_cnt + TDW'(1);
        end
    end

endmodule

// File: rtl/scroll_select_seq.sv
// Scroll select sequencer: rotates the eight display mux selects one position
// per prescaler tick (RUN) or per Step rising edge (PAUSE).
module scroll_select_seq
    import scroll_select_seq_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int TDW      = 26
) (
    input  logic                Clock,
    input  logic                Resetn,
    scroll_select_seq_if.slave  bus
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_en;
    logic                 w_wrap;
    logic                 r_step_d;
    logic                 w_step_rise;
    logic                 w_advance;
    logic [SELW-1:0]      r_offset;
    logic [SELW-1:0]      w_offset_nxt;
    logic                 r_tick;
    logic [NPOS*SELW-1:0] r_sel;
    logic [NPOS*SELW-1:0] w_sel_nxt;
    logic [NPOS*SELW-1:0] w_sel_rst;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .TDW      (TDW)
    ) u_prescaler (
        .Clock  (Clock),
        .Resetn (Resetn),
        .En     (w_en),
        .Tick   (w_wrap)
    );

    // FSM state register.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state <= PAUSE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state follows Run one edge later; prescaler is enabled only in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_en        = 1'b0;
        case (r_state)
            PAUSE: begin
                if (bus.Run) w_state_nxt = RUN;
            end
            RUN: begin
                w_en = 1'b1;
                if (!bus.Run) w_state_nxt = PAUSE;
            end
            default: w_state_nxt = PAUSE;
        endcase
    end

    // A Step edge only counts while paused; in RUN the prescaler wrap is the only source.
    assign w_step_rise = bus.Step & ~r_step_d;
    assign w_advance   = w_wrap | ((r_state == PAUSE) & w_step_rise);

    // Dir is taken from the advancing cycle itself; 3-bit arithmetic gives the mod-8 wrap.
    assign w_offset_nxt = !w_advance ? r_offset :
                          bus.Dir    ? r_offset - SELW'(1) :
                                       r_offset + SELW'(1);

    // Lane selects are derived from the next offset so Sel lands on the same edge as Offset.
    for (genvar g = 0; g < NPOS; g++) begin : g_lane
        assign w_sel_nxt[g*SELW +: SELW] = lane_sel(w_offset_nxt, g);
        assign w_sel_rst[g*SELW +: SELW] = lane_sel('0, g);
    end

    // Step history, offset, tick pulse and lane selects.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_step_d <= 1'b0;
            r_offset <= '0;
            r_tick   <= 1'b0;
            r_sel    <= w_sel_rst;
        end else begin
            r_step_d <= bus.Step;
            r_offset <= w_offset_nxt;
            r_tick   <= w_advance;
            r_sel    <= w_sel_nxt;
        end
    end

    assign bus.Offset = r_offset;
    assign bus.Sel    = r_sel;
    assign bus.Tick   = r_tick;

endmodule

// File: tb/tb_scroll_select_seq.sv
// Bench for scroll_select_seq with a fast prescaler (TICK_DIV = 4).
module tb_scroll_select_seq;
    import scroll_select_seq_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int TDW      = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    scroll_select_seq_if bus ();

    scroll_select_seq #(
        .TICK_DIV (TICK_DIV),
        .TDW      (TDW)
    ) dut (
        .Clock  (clk),
        .Resetn (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: run flag, phase within the step period, offset 0..7.
    bit m_run;
    int m_phase;
    int m_off;
    bit m_tick;
    bit m_step_prev;

    function automatic logic [31:0] model_sel(input int off);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s[3*i +: 3] = 3'((off + i) % 8);
        return s;
    endfunction

    always @(posedge clk) begin
        bit adv;
        adv = 1'b0;
        if (!rstn) begin
            m_run       <= 1'b0;
            m_phase     <= 0;
            m_off       <= 0;
            m_tick      <= 1'b0;
            m_step_prev <= 1'b0;
        end else begin
            if (m_run) begin
                if (m_phase == TICK_DIV - 1) begin
                    adv = 1'b1;
                    m_phase <= 0;
                end else begin
                    m_phase <= m_phase + 1;
                end
            end else if (bus.Step && !m_step_prev) begin
                adv = 1'b1;
            end
            if (adv) m_off <= bus.Dir ? (m_off + 7) % 8 : (m_off + 1) % 8;
            m_tick      <= adv;
            m_run       <= bus.Run;
            m_step_prev <= bus.Step;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_offset", 32'(bus.Offset), 32'(m_off));
            check("cyc_sel", 32'(bus.Sel), model_sel(m_off));
            check("cyc_tick", 32'(bus.Tick), 32'(m_tick));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(input int max, output int k);
        k = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (bus.Tick === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int k, ticks, first, prev, gap_bad, consec;
        bit last_tick;
        logic step_seq [9];

        bus.Run  = 1'b0;
        bus.Dir  = 1'b0;
        bus.Step = 1'b0;
        rstn     = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_offset", 32'(bus.Offset), 0);
        check("rst_sel", 32'(bus.Sel), 32'o76543210);
        check("rst_tick", 32'(bus.Tick), 0);

        // 1: auto-scroll left
        rstn = 1'b1; bus.Run = 1'b1; bus.Dir = 1'b0;
        ticks = 0; first = -1; prev = -1; gap_bad = 0;
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            if (bus.Tick === 1'b1) begin
                if (prev >= 0 && c - prev != 4) gap_bad++;
                if (first < 0) first = c;
                prev = c;
                ticks++;
            end
        end
        check("t1_first_tick", 32'(first), 5);
        check("t1_ticks", 32'(ticks), 10);
        check("t1_gaps", 32'(gap_bad), 0);
        check("t1_offset", 32'(bus.Offset), 2);
        check("t1_lane0", 32'(bus.Sel[2:0]), 2);
        check("t1_lane7", 32'(bus.Sel[23:21]), 1);

        // 2: scroll right from 0 wraps to 7
        rstn = 1'b0; bus.Run = 1'b0;
        @(negedge clk);
        rstn = 1'b1; bus.Run = 1'b1; bus.Dir = 1'b1;
        wait_tick(10, k);
        check("t2_tick_at", 32'(k), 5);
        check("t2_offset", 32'(bus.Offset), 7);
        check("t2_sel", 32'(bus.Sel), 32'o65432107);

        // 3: pause mid-period keeps the phase
        bus.Dir = 1'b0;
        cyc(2);
        bus.Run = 1'b0;
        ticks = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (bus.Tick === 1'b1) ticks++;
        end
        check("t3_pause_ticks", 32'(ticks), 0);
        check("t3_pause_offset", 32'(bus.Offset), 7);
        bus.Run = 1'b1;
        wait_tick(10, k);
        check("t3_resume_tick_at", 32'(k), 2);
        check("t3_offset", 32'(bus.Offset), 0);

        // 4: single-step while paused, then Step ignored while running
        bus.Run = 1'b0;
        cyc(2);
        step_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        ticks = 0; consec = 0; last_tick = 1'b0;
        for (int c = 0; c < 9; c++) begin
            bus.Step = step_seq[c];
            @(negedge clk);
            if (bus.Tick === 1'b1) begin
                ticks++;
                if (last_tick) consec++;
            end
            last_tick = (bus.Tick === 1'b1);
        end
        check("t4_step_ticks", 32'(ticks), 2);
        check("t4_step_consec", 32'(consec), 0);
        check("t4_step_offset", 32'(bus.Offset), 2);
        bus.Run = 1'b1;
        cyc(1);
        ticks = 0;
        for (int c = 0; c < 6; c++) begin
            bus.Step = (c % 2 == 0);
            @(negedge clk);
            if (bus.Tick === 1'b1) ticks++;
        end
        bus.Step = 1'b0;
        check("t4_run_ticks", 32'(ticks), 1);
        check("t4_run_offset", 32'(bus.Offset), 3);

        // 5: reset mid-count discards the partial period
        wait_tick(10, k);
        check("t5_tick_a", 32'(k), 1);
        wait_tick(10, k);
        check("t5_tick_b", 32'(k), 4);
        check("t5_offset5", 32'(bus.Offset), 5);
        cyc(2);
        rstn = 1'b0;
        @(negedge clk);
        check("t5_rst_offset", 32'(bus.Offset), 0);
        check("t5_rst_tick", 32'(bus.Tick), 0);
        check("t5_rst_sel", 32'(bus.Sel), 32'o76543210);
        rstn = 1'b1;
        wait_tick(10, k);
        check("t5_first_tick_at", 32'(k), 5);
        check("t5_offset", 32'(bus.Offset), 1);

        // 6: Run rising together with a Step edge
        cyc(3);
        bus.Run = 1'b0;
        @(negedge clk);
        check("t6_wrap_tick", 32'(bus.Tick), 1);
        check("t6_wrap_offset", 32'(bus.Offset), 2);
        cyc(2);
        bus.Run = 1'b1; bus.Step = 1'b1;
        @(negedge clk);
        check("t6_step_tick", 32'(bus.Tick), 1);
        check("t6_step_offset", 32'(bus.Offset), 3);
        bus.Step = 1'b0;
        wait_tick(10, k);
        check("t6_next_tick_at", 32'(k), 4);
        check("t6_offset", 32'(bus.Offset), 4);

        cyc(2);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
